// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg: shared MDIO opcodes, register indices, reset values and responder states
package eth_mdio_pkg;

    localparam logic [1:0]  OP_RD      = 2'b10;
    localparam logic [1:0]  OP_WR      = 2'b01;

    localparam logic [4:0]  REG_BMCR   = 5'd0;
    localparam logic [4:0]  REG_BMSR   = 5'd1;
    localparam logic [4:0]  REG_PHYID1 = 5'd2;
    localparam logic [4:0]  REG_PHYID2 = 5'd3;
    localparam logic [4:0]  REG_ANAR   = 5'd4;
    localparam logic [4:0]  REG_PHYSR  = 5'd17;

    localparam logic [15:0] BMCR_DEF   = 16'h1140;
    localparam logic [15:0] ANAR_DEF   = 16'h01E1;
    localparam logic [15:0] BMSR_BASE  = 16'h7949;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: double-flop synchronizers for MDC/MDIO and MDC rising-edge detect
module mdio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic mdio,
    output logic rise,
    output logic mdio_s
);

    logic [1:0] mdc_q;
    logic [1:0] mdio_q;
    logic       mdc_d;

    // Synchronize both pads; keep one extra MDC stage to spot a 0->1 transition
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_q  <= '0;
            mdio_q <= '0;
            mdc_d  <= 1'b0;
        end else begin
            mdc_q  <= {mdc_q[0], mdc};
            mdio_q <= {mdio_q[0], mdio};
            mdc_d  <= mdc_q[1];
        end
    end

    assign rise   = mdc_q[1] & ~mdc_d;
    assign mdio_s = mdio_q[1];

endmodule

// File: rtl/mdio_phy_resp.sv
// mdio_phy_resp: Clause 22 MDIO management slave emulating a minimal PHY register set
module mdio_phy_resp
    import eth_mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter bit          BCAST_EN = 1'b1,
    parameter int          PRE_MIN  = 32,
    parameter logic [15:0] PHYID1   = 16'h001C,
    parameter logic [15:0] PHYID2   = 16'hC915,
    parameter int          TIMEOUT  = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        link_i,
    input  logic [1:0]  speed_i,
    input  logic        duplex_i,
    output logic [15:0] bmcr_o,
    output logic [15:0] anar_o,
    output logic        acc_o,
    output logic        acc_wr_o,
    output logic [4:0]  acc_reg_o,
    output logic        busy_o
);

    localparam int PW = $clog2(PRE_MIN + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, nxt;
    logic          rise, b;
    logic [PW-1:0] pre_cnt;
    logic [3:0]    bcnt;
    logic [TW-1:0] tmo;
    logic [1:0]    op;
    logic [4:0]    phyad, regad, rad;
    logic [15:0]   sh, rd_word, wdata;
    logic          link_lat, last, hit, is_rd, is_wr, tmo_hit, rd_done, wr_done;

    mdio_sync_edge u_sync (
        .clk    (clk_i),
        .rst    (rst_i),
        .mdc    (mdc_i),
        .mdio   (mdio_i),
        .rise   (rise),
        .mdio_s (b)
    );

    assign busy_o  = state != S_IDLE;
    assign last    = (state == S_OP || state == S_TA) ? bcnt == 4'd1 :
                     (state == S_PHYAD || state == S_REGAD) ? bcnt == 4'd4 :
                     (state == S_DATA) ? bcnt == 4'd15 : 1'b0;
    assign hit     = phyad == PHY_ADDR || (BCAST_EN && phyad == 5'd0);
    assign is_rd   = op == OP_RD;
    assign is_wr   = op == OP_WR;
    assign tmo_hit = busy_o && !rise && tmo == TW'(TIMEOUT - 1);
    assign rd_done = rise && state == S_DATA && last && is_rd && hit;
    assign wr_done = rise && state == S_DATA && last && is_wr && hit;
    assign wdata   = {sh[14:0], b};
    assign rad     = {regad[3:0], b};
    assign rd_word = (rad == REG_BMCR)   ? bmcr_o :
                     (rad == REG_BMSR)   ? (BMSR_BASE | {13'd0, link_lat, 2'd0}) :
                     (rad == REG_PHYID1) ? PHYID1 :
                     (rad == REG_PHYID2) ? PHYID2 :
                     (rad == REG_ANAR)   ? anar_o :
                     (rad == REG_PHYSR)  ? {speed_i, duplex_i, 1'b0, 1'b1, link_i, 10'd0} : 16'd0;

    // Frame state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= nxt;
    end

    // Advance one frame field per MDC rise; a write with a bad turnaround is dropped
    always_comb begin
        nxt = state;
        if (tmo_hit) nxt = S_IDLE;
        else if (rise) begin
            case (state)
                S_IDLE:  nxt = (!b && pre_cnt >= PW'(PRE_MIN)) ? S_ST : S_IDLE;
                S_ST:    nxt = b ? S_OP : S_IDLE;
                S_OP:    nxt = !last ? S_OP : ({op[0], b} == OP_RD || {op[0], b} == OP_WR) ? S_PHYAD : S_IDLE;
                S_PHYAD: nxt = last ? S_REGAD : S_PHYAD;
                S_REGAD: nxt = last ? S_TA : S_REGAD;
                S_TA:    nxt = (is_wr && hit && (bcnt == 4'd0 ? !b : b)) ? S_IDLE : last ? S_DATA : S_TA;
                S_DATA:  nxt = last ? S_IDLE : S_DATA;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Field capture, read shifting, register writes, link latch and access pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt   <= '0;
            bcnt      <= '0;
            tmo       <= '0;
            op        <= '0;
            phyad     <= '0;
            regad     <= '0;
            sh        <= '0;
            link_lat  <= 1'b0;
            bmcr_o    <= BMCR_DEF;
            anar_o    <= ANAR_DEF;
            mdio_o    <= 1'b0;
            mdio_oe_o <= 1'b0;
            acc_o     <= 1'b0;
            acc_wr_o  <= 1'b0;
            acc_reg_o <= '0;
        end else begin
            acc_o    <= 1'b0;
            tmo      <= (state == S_IDLE || rise) ? '0 : tmo + 1'b1;
            link_lat <= link_i && (link_lat || (rd_done && regad == REG_BMSR));
            if (tmo_hit) begin
                mdio_oe_o <= 1'b0;
                mdio_o    <= 1'b0;
                bcnt      <= '0;
            end else if (rise) begin
                bcnt <= (last || state == S_IDLE || state == S_ST || nxt == S_IDLE) ? '0 : bcnt + 1'b1;
                case (state)
                    S_IDLE:  pre_cnt <= !b ? '0 : (pre_cnt < PW'(PRE_MIN)) ? pre_cnt + 1'b1 : pre_cnt;
                    S_OP:    op <= {op[0], b};
                    S_PHYAD: phyad <= {phyad[3:0], b};
                    S_REGAD: begin
                        regad <= rad;
                        if (last) sh <= rd_word;
                    end
                    S_TA: if (is_rd && hit) begin
                        if (bcnt == 4'd0) begin
                            mdio_oe_o <= 1'b1;
                            mdio_o    <= 1'b0;
                        end else begin
                            mdio_o <= sh[15];
                            sh     <= {sh[14:0], 1'b0};
                        end
                    end
                    S_DATA: begin
                        if (is_wr) sh <= wdata;
                        if (is_rd && hit) begin
                            mdio_oe_o <= !last;
                            mdio_o    <= last ? 1'b0 : sh[15];
                            sh        <= {sh[14:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
            if (wr_done && regad == REG_BMCR && wdata[15]) begin
                bmcr_o <= BMCR_DEF;
                anar_o <= ANAR_DEF;
            end else if (wr_done && regad == REG_BMCR) bmcr_o <= wdata;
            else if (wr_done && regad == REG_ANAR) anar_o <= wdata;
            if (rd_done || wr_done) begin
                acc_o     <= 1'b1;
                acc_wr_o  <= wr_done;
                acc_reg_o <= regad;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_resp.sv
// tb_mdio_phy_resp: directed MDIO station driving frames at the responder with hand-computed expectations
module tb_mdio_phy_resp;
    import eth_mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        drv = 1'b1;
    logic        link = 1'b1;
    logic [1:0]  speed = 2'b10;
    logic        duplex = 1'b1;
    logic        mdio, mdio_o, mdio_oe, acc, acc_wr, busy;
    logic [4:0]  acc_reg;
    logic [15:0] bmcr, anar;
    logic [15:0] d;
    logic        t2;
    int          checks = 0;
    int          errors = 0;
    int          acc_n = 0;
    int          oe_n = 0;
    logic        last_wr = 1'b0;
    logic [4:0]  last_reg = '0;
    int          a0, o0;

    assign mdio = mdio_oe ? mdio_o : drv;

    mdio_phy_resp dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .mdc_i     (mdc),
        .mdio_i    (mdio),
        .mdio_o    (mdio_o),
        .mdio_oe_o (mdio_oe),
        .link_i    (link),
        .speed_i   (speed),
        .duplex_i  (duplex),
        .bmcr_o    (bmcr),
        .anar_o    (anar),
        .acc_o     (acc),
        .acc_wr_o  (acc_wr),
        .acc_reg_o (acc_reg),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acc === 1'b1) begin
            acc_n    <= acc_n + 1;
            last_wr  <= acc_wr;
            last_reg <= acc_reg;
        end
        if (mdio_oe === 1'b1) oe_n <= oe_n + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_io(input logic bv, output logic s);
        drv = bv;
        repeat (5) @(negedge clk);
        s = mdio;
        mdc = 1'b1;
        repeat (5) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_hdr(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra, input int pre);
        logic        s;
        logic [13:0] h;
        h = {2'b01, op, pa, ra};
        for (int i = 0; i < pre; i++) bit_io(1'b1, s);
        for (int i = 13; i >= 0; i--) bit_io(h[i], s);
    endtask

    task automatic rd_frame(input logic [4:0] pa, input logic [4:0] ra, input int pre,
                            output logic [15:0] dv, output logic ta2);
        logic s;
        send_hdr(OP_RD, pa, ra, pre);
        bit_io(1'b1, s);
        bit_io(1'b1, ta2);
        for (int i = 15; i >= 0; i--) begin
            bit_io(1'b1, s);
            dv[i] = s;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wr_frame(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        logic s;
        send_hdr(OP_WR, pa, ra, 32);
        bit_io(1'b1, s);
        bit_io(1'b0, s);
        for (int i = 15; i >= 0; i--) bit_io(wd[i], s);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic s;
        repeat (4) @(negedge clk);
        chk("rst_bmcr", bmcr, 16'h1140);
        chk("rst_anar", anar, 16'h01E1);
        chk("rst_oe", {15'd0, mdio_oe}, 16'd0);
        chk("rst_o", {15'd0, mdio_o}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_acc", {15'd0, acc}, 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        a0 = acc_n;
        rd_frame(5'd1, 5'd2, 32, d, t2);
        chk("rd_phyid1", d, 16'h001C);
        chk("rd_ta2_zero", {15'd0, t2}, 16'd0);
        chk("rd_oe_after", {15'd0, mdio_oe}, 16'd0);
        chk("rd_acc_cnt", 16'(acc_n - a0), 16'd1);
        chk("rd_acc_wr", {15'd0, last_wr}, 16'd0);
        chk("rd_acc_reg", {11'd0, last_reg}, 16'd2);

        a0 = acc_n;
        wr_frame(5'd1, 5'd4, 16'h05E1);
        chk("wr_anar_o", anar, 16'h05E1);
        chk("wr_acc_cnt", 16'(acc_n - a0), 16'd1);
        chk("wr_acc_wr", {15'd0, last_wr}, 16'd1);
        chk("wr_acc_reg", {11'd0, last_reg}, 16'd4);
        chk("wr_busy_after", {15'd0, busy}, 16'd0);
        rd_frame(5'd1, 5'd4, 32, d, t2);
        chk("rd_anar", d, 16'h05E1);

        rd_frame(5'd1, 5'd1, 32, d, t2);
        chk("bmsr_first", d, 16'h7949);
        rd_frame(5'd1, 5'd1, 32, d, t2);
        chk("bmsr_latched", d, 16'h794D);
        link = 1'b0;
        repeat (3) @(negedge clk);
        link = 1'b1;
        rd_frame(5'd1, 5'd1, 32, d, t2);
        chk("bmsr_after_drop", d, 16'h7949);
        rd_frame(5'd1, 5'd1, 32, d, t2);
        chk("bmsr_relatched", d, 16'h794D);

        rd_frame(5'd1, 5'd17, 32, d, t2);
        chk("physr", d, 16'hAC00);
        rd_frame(5'd1, 5'd3, 32, d, t2);
        chk("phyid2", d, 16'hC915);

        wr_frame(5'd1, 5'd0, 16'h8000);
        chk("bmcr_rst_anar", anar, 16'h01E1);
        chk("bmcr_rst_bmcr", bmcr, 16'h1140);
        rd_frame(5'd1, 5'd0, 32, d, t2);
        chk("bmcr_rst_read", d, 16'h1140);
        wr_frame(5'd1, 5'd0, 16'h1340);
        chk("bmcr_wr", bmcr, 16'h1340);

        a0 = acc_n;
        o0 = oe_n;
        rd_frame(5'd5, 5'd2, 32, d, t2);
        chk("mis_oe", 16'(oe_n - o0), 16'd0);
        chk("mis_acc", 16'(acc_n - a0), 16'd0);
        chk("mis_data", d, 16'hFFFF);
        rd_frame(5'd1, 5'd2, 32, d, t2);
        chk("after_mis", d, 16'h001C);
        rd_frame(5'd0, 5'd2, 32, d, t2);
        chk("bcast", d, 16'h001C);

        a0 = acc_n;
        o0 = oe_n;
        rd_frame(5'd1, 5'd2, 20, d, t2);
        chk("short_pre_oe", 16'(oe_n - o0), 16'd0);
        chk("short_pre_acc", 16'(acc_n - a0), 16'd0);

        a0 = acc_n;
        rd_frame(5'd1, 5'd7, 32, d, t2);
        chk("unk_reg", d, 16'h0000);
        chk("unk_acc", 16'(acc_n - a0), 16'd1);

        a0 = acc_n;
        send_hdr(OP_RD, 5'd1, 5'd2, 32);
        chk("tmo_busy_hdr", {15'd0, busy}, 16'd1);
        repeat (3000) @(negedge clk);
        chk("tmo_busy_wait", {15'd0, busy}, 16'd1);
        repeat (1200) @(negedge clk);
        chk("tmo_busy_done", {15'd0, busy}, 16'd0);
        chk("tmo_oe", {15'd0, mdio_oe}, 16'd0);
        chk("tmo_acc", 16'(acc_n - a0), 16'd0);
        rd_frame(5'd1, 5'd2, 32, d, t2);
        chk("after_tmo", d, 16'h001C);

        wr_frame(5'd1, 5'd4, 16'h0DE1);
        chk("anar_pre_rst", anar, 16'h0DE1);
        send_hdr(OP_RD, 5'd1, 5'd4, 32);
        bit_io(1'b1, s);
        bit_io(1'b1, s);
        for (int i = 0; i < 3; i++) bit_io(1'b1, s);
        chk("midrd_oe", {15'd0, mdio_oe}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_oe", {15'd0, mdio_oe}, 16'd0);
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        chk("rst_mid_anar", anar, 16'h01E1);
        chk("rst_mid_bmcr", bmcr, 16'h1140);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_frame(5'd1, 5'd2, 32, d, t2);
        chk("after_rst", d, 16'h001C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
